// File: rtl/mixcolum_ctrl.sv
// mixcolum_ctrl: runs one shared 32-bit word_mixcolum datapath over a 128-bit AES state.
// The state is processed one column per cycle.
//   clk        rising-edge clock
//   reset      asynchronous active-low reset
//   in_valid   state_in/decrypt_in valid       in_ready   a state can be accepted
//   decrypt_in 0 = MixColumns, 1 = InvMixColumns (sampled on accept)
//   state_in   column 0 = [127:96] .. column 3 = [31:0]
//   mix_word   column driven to the datapath   mix_outx/y datapath results for mix_word
//   out_valid  state_out holds a full result   out_ready  downstream takes state_out
//   state_out  mixed state, same layout        busy       high while mixing or holding a result
// REG_IN=1 registers mix_word. This adds one MIX cycle and delays every capture by one column.
module mixcolum_ctrl #(
   parameter int unsigned REG_IN = 0
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic         decrypt_in,
   input  logic [127:0] state_in,
   output logic [31:0]  mix_word,
   input  logic [31:0]  mix_outx,
   input  logic [31:0]  mix_outy,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] state_out,
   output logic         busy
);

   localparam int unsigned     ColW    = (REG_IN != 0) ? 3 : 2;
   localparam logic [ColW-1:0] LastCol = ColW'((REG_IN != 0) ? 4 : 3);

   typedef enum logic [1:0] {StIdle, StMix, StDone} state_e;

   state_e           state_q;
   logic [ColW-1:0]  col_q;
   logic             mode_q;
   logic             out_valid_q;
   logic             busy_q;
   logic [0:3][31:0] src_q;     // index 0 is the MSB column
   logic [0:3][31:0] result_q;

   logic        accept;
   logic        cap_en;
   logic [1:0]  cap_idx;
   logic [31:0] mix_res;

   always_comb begin
      cap_en   = 1'b0;
      cap_idx  = '0;
      in_ready = (state_q == StIdle) || ((state_q == StDone) && out_ready);
      accept   = in_valid && in_ready;
      mix_res  = mode_q ? mix_outy : mix_outx;
      if (REG_IN != 0) begin
         // The datapath sees src[col-1] while col is active, so capture lags by one column.
         cap_en  = (state_q == StMix) && (col_q != '0);
         cap_idx = col_q[1:0] - 2'd1;
      end else begin
         cap_en  = (state_q == StMix);
         cap_idx = col_q[1:0];
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= StIdle;
         col_q       <= '0;
         mode_q      <= 1'b0;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         src_q       <= '0;
         result_q    <= '0;
      end else begin
         case (state_q)
            StIdle: ;
            StMix: begin
               if (col_q == LastCol) begin
                  state_q     <= StDone;
                  col_q       <= '0;
                  out_valid_q <= 1'b1;
               end else begin
                  col_q <= col_q + ColW'(1);
               end
            end
            StDone: begin
               if (out_ready) begin
                  state_q     <= StIdle;
                  out_valid_q <= 1'b0;
                  busy_q      <= 1'b0;
               end
            end
            default: begin
               state_q     <= StIdle;
               out_valid_q <= 1'b0;
               busy_q      <= 1'b0;
            end
         endcase

         if (cap_en) begin
            result_q[cap_idx] <= mix_res;
         end

         // An accept overrides the DONE->IDLE step, so back-to-back states have no bubble.
         if (accept) begin
            state_q     <= StMix;
            col_q       <= '0;
            mode_q      <= decrypt_in;
            src_q       <= state_in;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b1;
         end
      end
   end

   if (REG_IN != 0) begin : g_reg_in
      logic [31:0] mix_word_q;

      // Loads columns 0..3; the terminal column and every non-MIX cycle drive zero.
      always_ff @(posedge clk or negedge reset) begin
         if (!reset) begin
            mix_word_q <= '0;
         end else if ((state_q == StMix) && (col_q != LastCol)) begin
            mix_word_q <= src_q[col_q[1:0]];
         end else begin
            mix_word_q <= '0;
         end
      end

      assign mix_word = mix_word_q;
   end else begin : g_comb_in
      assign mix_word = (state_q == StMix) ? src_q[col_q[1:0]] : '0;
   end

   assign out_valid = out_valid_q;
   assign busy      = busy_q;
   assign state_out = result_q;

endmodule

// File: tb/tb_mixcolum_ctrl.sv
module tb_mixcolum_ctrl;

   logic         clk;
   logic         reset;
   logic         in_valid   [2];
   logic         in_ready   [2];
   logic         decrypt_in [2];
   logic [127:0] state_in   [2];
   logic [31:0]  mix_word   [2];
   logic [31:0]  mix_outx   [2];
   logic [31:0]  mix_outy   [2];
   logic         out_valid  [2];
   logic         out_ready  [2];
   logic [127:0] state_out  [2];
   logic         busy       [2];

   int          total;
   int          passed;
   logic [31:0] wseq [0:20];

   localparam logic [127:0] V1In  = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
   localparam logic [127:0] V1Out = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
   localparam logic [127:0] V2In  = 128'h8e4da1bc_9fdc589d_d5d5d7d6_4d7ebdf8;
   localparam logic [127:0] V2Out = 128'hdb135345_f20a225c_d4d4d4d5_2d26314c;

   // Reference GF(2^8) arithmetic for the column mix.
   function automatic logic [7:0] xt(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [3:0] k);
      logic [7:0] p;
      logic [7:0] x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 4; i++) begin
         if (k[i]) p = p ^ x;
         x = xt(x);
      end
      return p;
   endfunction

   function automatic logic [31:0] mixcol(input logic [31:0] w, input logic inv);
      logic [3:0]  base [4];
      logic [7:0]  a    [4];
      logic [7:0]  r;
      logic [31:0] o;
      if (inv) begin
         base[0] = 4'he; base[1] = 4'hb; base[2] = 4'hd; base[3] = 4'h9;
      end else begin
         base[0] = 4'h2; base[1] = 4'h3; base[2] = 4'h1; base[3] = 4'h1;
      end
      for (int c = 0; c < 4; c++) a[c] = w[31-8*c -: 8];
      o = '0;
      for (int rr = 0; rr < 4; rr++) begin
         r = 8'h00;
         for (int c = 0; c < 4; c++) r = r ^ gmul(a[c], base[(c - rr) & 3]);
         o[31-8*rr -: 8] = r;
      end
      return o;
   endfunction

   function automatic logic [127:0] mix_state(input logic [127:0] s, input logic dec);
      logic [127:0] o;
      for (int c = 0; c < 4; c++) o[127-32*c -: 32] = mixcol(s[127-32*c -: 32], dec);
      return o;
   endfunction

   // Behavioural word_mixcolum datapaths.
   assign mix_outx[0] = mixcol(mix_word[0], 1'b0);
   assign mix_outy[0] = mixcol(mix_word[0], 1'b1);
   assign mix_outx[1] = mixcol(mix_word[1], 1'b0);
   assign mix_outy[1] = mixcol(mix_word[1], 1'b1);

   mixcolum_ctrl #(.REG_IN(0)) dut0 (
      .clk        (clk),
      .reset      (reset),
      .in_valid   (in_valid[0]),
      .in_ready   (in_ready[0]),
      .decrypt_in (decrypt_in[0]),
      .state_in   (state_in[0]),
      .mix_word   (mix_word[0]),
      .mix_outx   (mix_outx[0]),
      .mix_outy   (mix_outy[0]),
      .out_valid  (out_valid[0]),
      .out_ready  (out_ready[0]),
      .state_out  (state_out[0]),
      .busy       (busy[0])
   );

   mixcolum_ctrl #(.REG_IN(1)) dut1 (
      .clk        (clk),
      .reset      (reset),
      .in_valid   (in_valid[1]),
      .in_ready   (in_ready[1]),
      .decrypt_in (decrypt_in[1]),
      .state_in   (state_in[1]),
      .mix_word   (mix_word[1]),
      .mix_outx   (mix_outx[1]),
      .mix_outy   (mix_outy[1]),
      .out_valid  (out_valid[1]),
      .out_ready  (out_ready[1]),
      .state_out  (state_out[1]),
      .busy       (busy[1])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Cycle 1 is the first cycle after the accept edge; returns -1 if out_valid never rises.
   task automatic wait_valid(input int d, output int lat);
      lat = -1;
      for (int k = 1; k <= 20; k++) begin
         if (out_valid[d]) begin
            lat = k;
            break;
         end
         wseq[k] = mix_word[d];
         @(negedge clk);
      end
   endtask

   // One full operation with out_ready held high; records mix_word per cycle in wseq.
   task automatic do_op(input int d, input logic [127:0] st, input logic dec, input bit toggle,
                        output logic [127:0] res, output int lat);
      res = 'x;
      lat = -1;
      @(negedge clk);
      in_valid[d]   = 1'b1;
      state_in[d]   = st;
      decrypt_in[d] = dec;
      @(negedge clk);
      in_valid[d] = 1'b0;
      for (int k = 1; k <= 20; k++) begin
         if (out_valid[d]) begin
            lat = k;
            res = state_out[d];
            break;
         end
         wseq[k] = mix_word[d];
         if (toggle) begin
            state_in[d]   = {$urandom, $urandom, $urandom, $urandom};
            decrypt_in[d] = 1'($urandom);
         end
         @(negedge clk);
      end
      @(negedge clk);
   endtask

   task automatic test_reset();
      reset = 1'b0;
      repeat (3) @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         total++;
         if (in_ready[d] !== 1'b1 || out_valid[d] !== 1'b0 || busy[d] !== 1'b0 ||
             mix_word[d] !== 32'h0 || state_out[d] !== 128'h0)
            $display("FAIL reset_state d=%0d got rdy=%b vld=%b busy=%b w=%h out=%h exp 1 0 0 0 0",
                     d, in_ready[d], out_valid[d], busy[d], mix_word[d], state_out[d]);
         else passed++;
      end
      reset = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_vectors(input int d);
      logic [127:0] res;
      logic [31:0]  wexp;
      int           lat;
      int           lexp;
      lexp = (d == 0) ? 5 : 6;
      do_op(d, V1In, 1'b0, 1'b0, res, lat);
      total++;
      if (res !== V1Out) $display("FAIL enc_vector d=%0d got %h exp %h", d, res, V1Out);
      else passed++;
      total++;
      if (lat !== lexp) $display("FAIL enc_latency d=%0d got %0d exp %0d", d, lat, lexp);
      else passed++;
      for (int k = 1; k < lexp; k++) begin
         if (d == 0) wexp = V1In[127-32*(k-1) -: 32];
         else wexp = (k == 1) ? 32'h0 : V1In[127-32*(k-2) -: 32];
         total++;
         if (wseq[k] !== wexp) $display("FAIL mix_word_seq d=%0d cyc=%0d got %h exp %h",
                                        d, k, wseq[k], wexp);
         else passed++;
      end
      total++;
      if (out_valid[d] !== 1'b0 || busy[d] !== 1'b0)
         $display("FAIL done_release d=%0d got vld=%b busy=%b exp 0 0", d, out_valid[d], busy[d]);
      else passed++;
      do_op(d, V2In, 1'b1, 1'b0, res, lat);
      total++;
      if (res !== V2Out) $display("FAIL dec_vector d=%0d got %h exp %h", d, res, V2Out);
      else passed++;
      total++;
      if (lat !== lexp) $display("FAIL dec_latency d=%0d got %0d exp %0d", d, lat, lexp);
      else passed++;
   endtask

   task automatic test_backpressure(input int d);
      int lat;
      int lexp;
      lexp = (d == 0) ? 5 : 6;
      @(negedge clk);
      out_ready[d]  = 1'b0;
      in_valid[d]   = 1'b1;
      state_in[d]   = V1In;
      decrypt_in[d] = 1'b0;
      @(negedge clk);
      in_valid[d] = 1'b0;
      wait_valid(d, lat);
      total++;
      if (lat !== lexp) $display("FAIL bp_latency d=%0d got %0d exp %0d", d, lat, lexp);
      else passed++;
      for (int i = 0; i < 10; i++) begin
         in_valid[d]   = 1'b1;
         state_in[d]   = {$urandom, $urandom, $urandom, $urandom};
         decrypt_in[d] = 1'($urandom);
         @(negedge clk);
         total++;
         if (state_out[d] !== V1Out || in_ready[d] !== 1'b0 || out_valid[d] !== 1'b1)
            $display("FAIL bp_hold d=%0d i=%0d got out=%h rdy=%b vld=%b exp %h 0 1",
                     d, i, state_out[d], in_ready[d], out_valid[d], V1Out);
         else passed++;
      end
      out_ready[d]  = 1'b1;
      in_valid[d]   = 1'b1;
      state_in[d]   = V2In;
      decrypt_in[d] = 1'b1;
      #1;
      total++;
      if (in_ready[d] !== 1'b1) $display("FAIL b2b_ready d=%0d got %b exp 1", d, in_ready[d]);
      else passed++;
      @(negedge clk);
      in_valid[d] = 1'b0;
      total++;
      if (busy[d] !== 1'b1 || out_valid[d] !== 1'b0)
         $display("FAIL b2b_no_bubble d=%0d got busy=%b vld=%b exp 1 0", d, busy[d], out_valid[d]);
      else passed++;
      wait_valid(d, lat);
      total++;
      if (lat !== lexp) $display("FAIL b2b_latency d=%0d got %0d exp %0d", d, lat, lexp);
      else passed++;
      total++;
      if (state_out[d] !== V2Out) $display("FAIL b2b_result d=%0d got %h exp %h",
                                           d, state_out[d], V2Out);
      else passed++;
      @(negedge clk);
   endtask

   task automatic test_reset_mid(input int d);
      logic [127:0] res;
      int           lat;
      @(negedge clk);
      in_valid[d]   = 1'b1;
      state_in[d]   = V1In;
      decrypt_in[d] = 1'b0;
      @(negedge clk);
      in_valid[d] = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      #1;
      total++;
      if (out_valid[d] !== 1'b0 || busy[d] !== 1'b0 || mix_word[d] !== 32'h0 ||
          in_ready[d] !== 1'b1)
         $display("FAIL reset_mid d=%0d got vld=%b busy=%b w=%h rdy=%b exp 0 0 0 1",
                  d, out_valid[d], busy[d], mix_word[d], in_ready[d]);
      else passed++;
      @(negedge clk);
      reset = 1'b1;
      repeat (6) @(negedge clk);
      total++;
      if (out_valid[d] !== 1'b0 || busy[d] !== 1'b0)
         $display("FAIL reset_discard d=%0d got vld=%b busy=%b exp 0 0", d, out_valid[d], busy[d]);
      else passed++;
      do_op(d, V1In, 1'b0, 1'b0, res, lat);
      total++;
      if (res !== V1Out) $display("FAIL reset_recover d=%0d got %h exp %h", d, res, V1Out);
      else passed++;
   endtask

   task automatic test_toggle(input int d, input int n);
      logic [127:0] st;
      logic [127:0] res;
      logic [127:0] exp_res;
      logic         dec;
      int           lat;
      for (int i = 0; i < n; i++) begin
         st      = {$urandom, $urandom, $urandom, $urandom};
         dec     = 1'($urandom);
         exp_res = mix_state(st, dec);
         do_op(d, st, dec, 1'b1, res, lat);
         total++;
         if (res !== exp_res) $display("FAIL toggle d=%0d i=%0d got %h exp %h", d, i, res, exp_res);
         else passed++;
      end
   endtask

   task automatic test_random(input int d, input int n);
      logic [127:0] st;
      logic [127:0] res;
      logic [127:0] exp_res;
      logic         dec;
      int           lat;
      int           lexp;
      lexp = (d == 0) ? 5 : 6;
      for (int i = 0; i < n; i++) begin
         st      = {$urandom, $urandom, $urandom, $urandom};
         dec     = 1'($urandom);
         exp_res = mix_state(st, dec);
         do_op(d, st, dec, 1'b0, res, lat);
         total++;
         if (res !== exp_res || lat !== lexp)
            $display("FAIL random d=%0d i=%0d got %h lat=%0d exp %h lat=%0d",
                     d, i, res, lat, exp_res, lexp);
         else passed++;
      end
   endtask

   initial begin
      total  = 0;
      passed = 0;
      reset  = 1'b0;
      for (int d = 0; d < 2; d++) begin
         in_valid[d]   = 1'b0;
         decrypt_in[d] = 1'b0;
         state_in[d]   = '0;
         out_ready[d]  = 1'b1;
      end
      test_reset();
      for (int d = 0; d < 2; d++) begin
         test_vectors(d);
         test_backpressure(d);
         test_reset_mid(d);
         test_toggle(d, 4);
         test_random(d, 20);
      end
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
